adder_checker: RTL and testbench
================================

Name: adder_checker

Overview:
- Downstream stage of the exhaustive stimulus generator in the adder testbench.
- Consumes the generator's a/b/cin vectors and the adder-under-test's sum/cout outputs.
- Aligns stimulus to the adder's pipeline latency, computes the golden a+b+cin result, and compares the two.
- Counts checked vectors and mismatches, captures the first failing vector, and flags pass/fail once all 2^(2N+1) vectors have been checked.

Parameters:
- N, 4, operand width of the adder under test.
- LAT, 0, adder-under-test latency in clk cycles (0..15); stimulus delay-line depth.
- TOTAL, 2**(2*N+1), localparam: number of vectors in a full exhaustive sweep (512 for N=4).

Ports:
- clk  input  1  clock; all sampling on posedge (the generator updates on negedge).
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a checking run.
- a  input  N  generator operand A.
- b  input  N  generator operand B.
- cin  input  1  generator carry-in.
- sum  input  N  adder-under-test sum.
- cout  input  1  adder-under-test carry-out.
- checked  output  32  number of vectors compared so far.
- errors  output  32  mismatch count; saturates at 32'hFFFFFFFF.
- err_pulse  output  1  high for one cycle after a mismatching compare.
- done  output  1  run complete; held until rst.
- pass  output  1  valid when done=1: 1 iff errors==0.
- first_a  output  N  operand A of the first failing vector.
- first_b  output  N  operand B of the first failing vector.
- first_cin  output  1  carry-in of the first failing vector.
- first_got  output  N+1  {cout,sum} observed on the first failure.
- first_exp  output  N+1  expected {cout,sum} on the first failure.

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE, all delay-line stages and valid bits cleared, all outputs 0. rst has priority over every other input in every state.
- FSM states: IDLE, FILL, CHECK, DONE.
- IDLE: start=1 -> FILL if LAT>0, otherwise directly -> CHECK. The posedge that sees start also captures the first stimulus.
- Delay line: LAT stages of {a,b,cin,valid}. It shifts on every posedge while in FILL or CHECK. With LAT=0 the stimulus is used directly.
- FILL: remains for exactly LAT posedges (the first of which is the start edge), then -> CHECK.
- CHECK, each posedge:
  - exp = aligned_a + aligned_b + aligned_cin, computed at N+1 bits with no truncation.
  - got = {cout,sum}.
  - checked increments.
  - On mismatch: errors increments (saturating) and err_pulse=1 next cycle. If errors was 0 before this compare, first_* is captured.
  - first_* are written only once per run.
- Count-to-completion: the compare that makes checked==TOTAL moves to DONE. done=1 and pass=(final errors==0) are visible after that same edge.
- DONE: no further counting or capture; all outputs held until rst.
- start while not IDLE: ignored; no restart and no counter clear.
- Output timing: all outputs are registered and update on the posedge that performs the compare.
- Reset mid-run: all state is discarded. A new start is required, and the next run's counts are independent of the aborted run.
- Stimulus changing during FILL is captured normally; the checker does not qualify its inputs beyond start.

Test Plan:
- N=4, LAT=0, correct combinational adder, start -> exactly 512 compares; done=1 after the 512th; checked=512, errors=0, pass=1; err_pulse never asserted.
- N=4, LAT=0, sum[0] stuck-at-0 -> errors=256, pass=0 at done. First failure: first_a=1, first_b=0, first_cin=0, first_got=5'b00000, first_exp=5'b00001.
- N=4, LAT=2, adder registered twice -> FILL lasts 2 cycles; errors=0, checked=512, pass=1. Same DUT with the checker at LAT=1 -> errors>0, pass=0.
- rst asserted when checked=100 -> next cycle: state IDLE, checked=0, errors=0, done=0, first_*=0. A fresh start with a correct adder gives checked=512, errors=0.
- start pulsed again mid-CHECK at checked=50 -> ignored; counting continues to 512 with no reset of counters.
- rst held high together with start -> remains IDLE with all outputs 0.

Source files
------------

// File: rtl/adder_checker.sv
// adder_checker: scoreboard stage for an exhaustive adder sweep.
// It aligns the generator stimulus to the adder latency and computes a golden
// a+b+cin. It compares that against {cout,sum}, counts compares and
// mismatches, and latches the first failing vector. It reports done/pass
// once all 2^(2N+1) vectors have been checked.
module adder_checker #(
    parameter int N   = 4,
    parameter int LAT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    input  logic          cin,
    input  logic [N-1:0]  sum,
    input  logic          cout,
    output logic [31:0]   checked,
    output logic [31:0]   errors,
    output logic          err_pulse,
    output logic          done,
    output logic          pass,
    output logic [N-1:0]  first_a,
    output logic [N-1:0]  first_b,
    output logic          first_cin,
    output logic [N:0]    first_got,
    output logic [N:0]    first_exp
);

    localparam logic [31:0] TOTAL  = 32'(2 ** (2 * N + 1));
    localparam int          DLW    = 2 * N + 2;                  // {valid, a, b, cin}
    localparam logic [3:0]  LAT_M1 = 4'((LAT > 0) ? LAT - 1 : 0);
    localparam bit          LAT_ZERO = (LAT == 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    logic [3:0]      r_fill_cnt;
    logic [31:0]     r_checked;
    logic [31:0]     r_errors;
    logic            r_err_pulse;
    logic            r_done;
    logic            r_pass;
    logic [N-1:0]    r_first_a;
    logic [N-1:0]    r_first_b;
    logic            r_first_cin;
    logic [N:0]      r_first_got;
    logic [N:0]      r_first_exp;

    logic [DLW-1:0]  w_al;
    logic            w_al_valid;
    logic [N-1:0]    w_al_a;
    logic [N-1:0]    w_al_b;
    logic            w_al_cin;
    logic            w_shift;
    logic            w_cmp;
    logic [N:0]      w_exp;
    logic [N:0]      w_got;
    logic            w_mis;
    logic            w_last;
    logic [31:0]     w_err_next;

    // The start edge captures the first stimulus, so it shifts the delay line as well.
    assign w_shift = (r_state == ST_FILL) || (r_state == ST_CHECK) ||
                     ((r_state == ST_IDLE) && start);

    generate
        if (LAT == 0) begin : g_direct
            assign w_al = {1'b1, a, b, cin};
        end else begin : g_delay
            logic [DLW-1:0] r_dl [LAT];

            // Stimulus delay line: stage 0 takes the live inputs, the last stage feeds the compare.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < LAT; i++) begin
                        r_dl[i] <= '0;
                    end
                end else if (w_shift) begin
                    r_dl[0] <= {1'b1, a, b, cin};
                    for (int i = 1; i < LAT; i++) begin
                        r_dl[i] <= r_dl[i-1];
                    end
                end else begin
                    r_dl <= r_dl;
                end
            end

            assign w_al = r_dl[LAT-1];
        end
    endgenerate

    assign w_al_valid = w_al[DLW-1];
    assign w_al_a     = w_al[2*N:N+1];
    assign w_al_b     = w_al[N:1];
    assign w_al_cin   = w_al[0];

    // Golden result, mismatch detection and next-count computation for this edge.
    always_comb begin
        w_exp = {1'b0, w_al_a} + {1'b0, w_al_b} + {{N{1'b0}}, w_al_cin};
        w_got = {cout, sum};
        w_mis = (w_got != w_exp);
        // With no adder latency the start edge itself compares vector 0.
        if (r_state == ST_CHECK) begin
            w_cmp = w_al_valid;
        end else if ((r_state == ST_IDLE) && start && LAT_ZERO) begin
            w_cmp = w_al_valid;
        end else begin
            w_cmp = 1'b0;
        end
        w_last = ((r_checked + 32'd1) == TOTAL);
        if (r_errors == 32'hFFFF_FFFF) begin
            w_err_next = r_errors;
        end else begin
            w_err_next = r_errors + 32'd1;
        end
    end

    // Control FSM plus all registered results; rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_fill_cnt  <= 4'd0;
            r_checked   <= 32'd0;
            r_errors    <= 32'd0;
            r_err_pulse <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_first_a   <= '0;
            r_first_b   <= '0;
            r_first_cin <= 1'b0;
            r_first_got <= '0;
            r_first_exp <= '0;
        end else begin
            r_err_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // The start edge counts as the first FILL edge, so LAT=1 needs no FILL state.
                    if (start) begin
                        if (LAT > 1) begin
                            r_state    <= ST_FILL;
                            r_fill_cnt <= 4'd1;
                        end else begin
                            r_state    <= ST_CHECK;
                            r_fill_cnt <= 4'd0;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_FILL: begin
                    r_fill_cnt <= r_fill_cnt + 4'd1;
                    if (r_fill_cnt == LAT_M1) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_state <= ST_FILL;
                    end
                end
                ST_CHECK: r_state <= ST_CHECK;
                ST_DONE:  r_state <= ST_DONE;
                default:  r_state <= ST_IDLE;
            endcase

            if (w_cmp) begin
                r_checked <= r_checked + 32'd1;
                if (w_mis) begin
                    r_errors    <= w_err_next;
                    r_err_pulse <= 1'b1;
                    if (r_errors == 32'd0) begin
                        r_first_a   <= w_al_a;
                        r_first_b   <= w_al_b;
                        r_first_cin <= w_al_cin;
                        r_first_got <= w_got;
                        r_first_exp <= w_exp;
                    end
                end
                if (w_last) begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                    r_pass  <= (r_errors == 32'd0) && !w_mis;
                end
            end
        end
    end

    assign checked   = r_checked;
    assign errors    = r_errors;
    assign err_pulse = r_err_pulse;
    assign done      = r_done;
    assign pass      = r_pass;
    assign first_a   = r_first_a;
    assign first_b   = r_first_b;
    assign first_cin = r_first_cin;
    assign first_got = r_first_got;
    assign first_exp = r_first_exp;

endmodule

// File: tb/tb_adder_checker.sv
// Bench for adder_checker: exhaustive sweeps with a correct adder, a stuck-at
// sum[0] adder, and a twice-registered adder. It also covers mid-run reset,
// a stray start pulse and reset held together with start.
module tb_adder_checker;

    localparam int N   = 4;
    localparam int TOT = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         stuck = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         cin = 1'b0;
    logic [N:0]   comb_res;
    logic [N:0]   p1 = '0;
    logic [N:0]   p2 = '0;

    // Adder under test models: combinational (optionally sum[0] stuck low) and two-stage registered.
    always_comb begin
        comb_res = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
        if (stuck) comb_res[0] = 1'b0;
    end

    always @(posedge clk) begin
        p1 <= {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
        p2 <= p1;
    end

    logic [31:0] d0_checked, d0_errors, d1_checked, d1_errors, d2_checked, d2_errors;
    logic d0_err_pulse, d0_done, d0_pass, d1_err_pulse, d1_done, d1_pass, d2_err_pulse, d2_done, d2_pass;
    logic [N-1:0] d0_first_a, d0_first_b, d1_first_a, d1_first_b, d2_first_a, d2_first_b;
    logic d0_first_cin, d1_first_cin, d2_first_cin;
    logic [N:0] d0_first_got, d0_first_exp, d1_first_got, d1_first_exp, d2_first_got, d2_first_exp;

    adder_checker #(.N(N), .LAT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .sum(comb_res[N-1:0]), .cout(comb_res[N]),
        .checked(d0_checked), .errors(d0_errors), .err_pulse(d0_err_pulse), .done(d0_done), .pass(d0_pass),
        .first_a(d0_first_a), .first_b(d0_first_b), .first_cin(d0_first_cin),
        .first_got(d0_first_got), .first_exp(d0_first_exp));

    adder_checker #(.N(N), .LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .sum(p2[N-1:0]), .cout(p2[N]),
        .checked(d1_checked), .errors(d1_errors), .err_pulse(d1_err_pulse), .done(d1_done), .pass(d1_pass),
        .first_a(d1_first_a), .first_b(d1_first_b), .first_cin(d1_first_cin),
        .first_got(d1_first_got), .first_exp(d1_first_exp));

    adder_checker #(.N(N), .LAT(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .sum(p2[N-1:0]), .cout(p2[N]),
        .checked(d2_checked), .errors(d2_errors), .err_pulse(d2_err_pulse), .done(d2_done), .pass(d2_pass),
        .first_a(d2_first_a), .first_b(d2_first_b), .first_cin(d2_first_cin),
        .first_got(d2_first_got), .first_exp(d2_first_exp));

    int total = 0;
    int bad   = 0;

    // Scoreboard: expected err_pulse per vector, plus the bench's own first-failure record.
    bit         exp_q[$];
    int         m_err;
    bit         m_have;
    logic [8:0] m_first;
    logic [4:0] m_fgot;
    logic [4:0] m_fexp;

    task automatic drive(input logic [8:0] v);
        a   = v[3:0];
        b   = v[7:4];
        cin = v[8];
    endtask

    task automatic sb_push(input logic [8:0] v, input bit flt);
        logic [4:0] g;
        logic [4:0] o;
        g = {1'b0, v[3:0]} + {1'b0, v[7:4]} + {4'b0000, v[8]};
        o = g;
        if (flt) o[0] = 1'b0;
        if (o != g) begin
            m_err++;
            if (!m_have) begin
                m_have  = 1'b1;
                m_first = v;
                m_fgot  = o;
                m_fexp  = g;
            end
        end
        exp_q.push_back(o != g);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; stuck = 1'b0; drive(9'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Full LAT=0 sweep on dut0; optional stray start at restart_at, optional reset at abort_at.
    task automatic sweep(input bit flt, input int restart_at, input int abort_at, output bit aborted);
        bit         e;
        logic [4:0] fe;
        logic [4:0] fg;
        exp_q.delete();
        m_err = 0; m_have = 1'b0; m_first = '0; m_fgot = '0; m_fexp = '0;
        aborted = 1'b0;
        @(negedge clk);
        stuck = flt; drive(9'd0); start = 1'b1;
        sb_push(9'd0, flt);
        for (int k = 0; k < TOT; k++) begin
            @(negedge clk);
            start = 1'b0;
            e = exp_q.pop_front();
            total++;
            if (d0_err_pulse !== e) begin
                bad++;
                $display("FAIL sweep_err_pulse vec=%0d got=%b exp=%b", k, d0_err_pulse, e);
            end
            total++;
            if (d0_checked !== 32'(k + 1)) begin
                bad++;
                $display("FAIL sweep_checked vec=%0d got=%0d exp=%0d", k, d0_checked, k + 1);
            end
            if (k + 1 == abort_at) begin
                rst = 1'b1;
                aborted = 1'b1;
                break;
            end
            if (k + 1 == restart_at) start = 1'b1;
            if (k + 1 < TOT) begin
                drive(9'(k + 1));
                sb_push(9'(k + 1), flt);
            end
        end
        exp_q.delete();
        if (!aborted) begin
            fe = m_have ? m_fexp : 5'd0;
            fg = m_have ? m_fgot : 5'd0;
            total++;
            if ({d0_done, d0_checked} !== {1'b1, 32'(TOT)}) begin
                bad++;
                $display("FAIL sweep_done got done=%b checked=%0d exp done=1 checked=%0d", d0_done, d0_checked, TOT);
            end
            total++;
            if ({d0_errors, d0_pass} !== {32'(m_err), (m_err == 0)}) begin
                bad++;
                $display("FAIL sweep_errors got errors=%0d pass=%b exp errors=%0d pass=%b",
                         d0_errors, d0_pass, m_err, (m_err == 0));
            end
            total++;
            if ({d0_first_a, d0_first_b, d0_first_cin, d0_first_got, d0_first_exp} !==
                {m_first[3:0], m_first[7:4], m_first[8], fg, fe}) begin
                bad++;
                $display("FAIL sweep_first got a=%0d b=%0d cin=%b got=%b exp=%b want a=%0d b=%0d cin=%b got=%b exp=%b",
                         d0_first_a, d0_first_b, d0_first_cin, d0_first_got, d0_first_exp,
                         m_first[3:0], m_first[7:4], m_first[8], fg, fe);
            end
            // DONE holds everything regardless of further stimulus.
            for (int k = 0; k < 3; k++) begin
                drive(9'($urandom_range(0, 511)));
                @(negedge clk);
                total++;
                if ({d0_done, d0_checked, d0_errors, d0_err_pulse} !== {1'b1, 32'(TOT), 32'(m_err), 1'b0}) begin
                    bad++;
                    $display("FAIL done_hold got done=%b checked=%0d errors=%0d err_pulse=%b",
                             d0_done, d0_checked, d0_errors, d0_err_pulse);
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({d0_checked, d0_errors, d0_err_pulse, d0_done, d0_pass, d0_first_a, d0_first_b,
             d0_first_cin, d0_first_got, d0_first_exp} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got checked=%0d errors=%0d done=%b pass=%b exp all zero",
                     d0_checked, d0_errors, d0_done, d0_pass);
        end
        repeat (3) @(negedge clk);
        total++;
        if ({d0_checked, d0_done, d2_checked} !== '0) begin
            bad++;
            $display("FAIL idle_no_start got checked=%0d done=%b exp 0", d0_checked, d0_done);
        end
    endtask

    task automatic test_lat0_correct();
        bit ab;
        do_reset();
        sweep(1'b0, -1, -1, ab);
    endtask

    task automatic test_stuck_sum0();
        bit ab;
        do_reset();
        sweep(1'b1, -1, -1, ab);
        total++;
        if ({d0_errors, d0_pass, d0_first_a, d0_first_b, d0_first_cin, d0_first_got, d0_first_exp} !==
            {32'd256, 1'b0, 4'd1, 4'd0, 1'b0, 5'b00000, 5'b00001}) begin
            bad++;
            $display("FAIL stuck_summary got errors=%0d pass=%b a=%0d b=%0d cin=%b got=%b exp=%b",
                     d0_errors, d0_pass, d0_first_a, d0_first_b, d0_first_cin, d0_first_got, d0_first_exp);
        end
    endtask

    task automatic test_latency();
        int c2;
        do_reset();
        @(negedge clk);
        drive(9'd0); start = 1'b1;
        for (int k = 0; k < TOT + 2; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k < 3) begin
                c2 = (k >= 2) ? k - 1 : 0;
                total++;
                if ({d2_checked, d1_checked} !== {32'(c2), 32'(k)}) begin
                    bad++;
                    $display("FAIL fill_timing edge=%0d got lat2=%0d lat1=%0d exp lat2=%0d lat1=%0d",
                             k, d2_checked, d1_checked, c2, k);
                end
            end
            total++;
            if (d2_err_pulse !== 1'b0) begin
                bad++;
                $display("FAIL lat2_err_pulse edge=%0d got=%b exp=0", k, d2_err_pulse);
            end
            drive(9'(k + 1));
        end
        total++;
        if ({d2_done, d2_checked, d2_errors, d2_pass} !== {1'b1, 32'(TOT), 32'd0, 1'b1}) begin
            bad++;
            $display("FAIL lat2_result got done=%b checked=%0d errors=%0d pass=%b exp 1/512/0/1",
                     d2_done, d2_checked, d2_errors, d2_pass);
        end
        total++;
        if (!(d1_done === 1'b1 && d1_errors > 32'd0 && d1_pass === 1'b0)) begin
            bad++;
            $display("FAIL lat1_misaligned got done=%b errors=%0d pass=%b exp done=1 errors>0 pass=0",
                     d1_done, d1_errors, d1_pass);
        end
    endtask

    task automatic test_abort_mid_run();
        bit ab;
        do_reset();
        sweep(1'b1, -1, 100, ab);
        @(negedge clk);
        total++;
        if ({d0_checked, d0_errors, d0_err_pulse, d0_done, d0_pass, d0_first_a, d0_first_b,
             d0_first_cin, d0_first_got, d0_first_exp} !== '0) begin
            bad++;
            $display("FAIL abort_clear got checked=%0d errors=%0d first_a=%0d first_got=%b exp all zero",
                     d0_checked, d0_errors, d0_first_a, d0_first_got);
        end
        rst = 1'b0; stuck = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (d0_checked !== 32'd0) begin
            bad++;
            $display("FAIL abort_needs_start got checked=%0d exp 0", d0_checked);
        end
        sweep(1'b0, -1, -1, ab);
    endtask

    task automatic test_start_mid_check();
        bit ab;
        do_reset();
        sweep(1'b0, 50, -1, ab);
    endtask

    task automatic test_rst_with_start();
        do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if ({d0_checked, d0_errors, d0_err_pulse, d0_done, d0_pass, d0_first_a, d0_first_b,
                 d0_first_cin, d0_first_got, d0_first_exp, d2_checked} !== '0) begin
                bad++;
                $display("FAIL rst_start_idle cyc=%0d got checked=%0d done=%b exp zero", k, d0_checked, d0_done);
            end
        end
        rst = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({d0_checked, d0_done} !== '0) begin
            bad++;
            $display("FAIL rst_start_after got checked=%0d done=%b exp 0", d0_checked, d0_done);
        end
    endtask

    initial begin
        test_reset();
        test_lat0_correct();
        test_stuck_sum0();
        test_latency();
        test_abort_mid_run();
        test_start_mid_check();
        test_rst_with_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
